pulse_shaper_multi: RTL and testbench



---
 rtl/pulse_shaper_pkg.sv | 13 +
 rtl/pulse_shaper_ch.sv | 111 +++++++++++
 rtl/pulse_shaper_multi.sv | 39 +++
 tb/tb_pulse_shaper_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_shaper_pkg.sv
// Shared types and defaults for the multi-channel photon pulse shaper.
package pulse_shaper_pkg;

    localparam int unsigned DefCntW  = 8;
    localparam int unsigned DefLostW = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StDead  = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_shaper_ch.sv
// One shaper channel: trigger detect, pulse/dead-time FSM and saturating lost-event counter.
module pulse_shaper_ch
    import pulse_shaper_pkg::*;
#(
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned LOST_W = DefLostW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              mode,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [CNT_W-1:0]  cfg_dead,
    input  logic              lost_clr,
    output logic              pulse,
    output logic              busy,
    output logic [LOST_W-1:0] lost_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   dead_q, dead_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               prev_q;
    logic [LOST_W-1:0]  lost_q;
    logic               edge_det;
    logic               trig;

    // prev_q resets to 0, so an input already high at reset release reads as an edge
    assign edge_det = din & ~prev_q;
    assign trig     = mode ? edge_det : din;

    // State register; pulse/busy are flopped from the next state so they leave a flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            width_q <= '0;
            dead_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            dead_q  <= dead_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            prev_q  <= din;
        end
    end

    // Next-state logic; width/dead are latched only on a trigger so a running sequence is fixed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        dead_d  = dead_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d = StPulse;
                    cnt_d   = CNT_W'(1);
                    width_d = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
                    dead_d  = cfg_dead;
                end
            end
            StPulse: begin
                if (cnt_q == width_q) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (dead_q != '0) ? StDead : StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDead: begin
                if (cnt_q == dead_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode of the upcoming state
    always_comb begin
        pulse_d = (state_d == StPulse);
        busy_d  = (state_d != StIdle);
    end

    // Lost-event counter: edges seen while busy, saturating, clear has priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lost_q <= '0;
        end else if (lost_clr) begin
            lost_q <= '0;
        end else if (edge_det && busy_q && (lost_q != {LOST_W{1'b1}})) begin
            lost_q <= lost_q + LOST_W'(1);
        end
    end

    assign pulse      = pulse_q;
    assign busy       = busy_q;
    assign lost_count = lost_q;

endmodule

// File: rtl/pulse_shaper_multi.sv
// Multi-channel photon pulse shaper: N_CH independent channels sharing configuration.
module pulse_shaper_multi
    import pulse_shaper_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned LOST_W = DefLostW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          channel,
    input  logic                     mode,
    input  logic [CNT_W-1:0]         cfg_width,
    input  logic [CNT_W-1:0]         cfg_dead,
    input  logic                     lost_clr,
    output logic [N_CH-1:0]          pulse,
    output logic [N_CH-1:0]          busy,
    output logic [N_CH*LOST_W-1:0]   lost_count
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_shaper_ch #(
            .CNT_W  (CNT_W),
            .LOST_W (LOST_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .din        (channel[i]),
            .mode       (mode),
            .cfg_width  (cfg_width),
            .cfg_dead   (cfg_dead),
            .lost_clr   (lost_clr),
            .pulse      (pulse[i]),
            .busy       (busy[i]),
            .lost_count (lost_count[i*LOST_W +: LOST_W])
        );
    end

endmodule

// File: tb/tb_pulse_shaper_multi.sv
// Self-checking bench for pulse_shaper_multi: vector table, corner sequences, random vs model.
module tb_pulse_shaper_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 8;
    localparam int LOST_W = 4;
    localparam int LMAX   = 15;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        channel;
    logic                   mode;
    logic [CNT_W-1:0]       cfg_width;
    logic [CNT_W-1:0]       cfg_dead;
    logic                   lost_clr;
    logic [N_CH-1:0]        pulse;
    logic [N_CH-1:0]        busy;
    logic [N_CH*LOST_W-1:0] lost_count;

    int total = 0;
    int bad   = 0;

    // Reference model: remaining pulse / dead cycles per channel
    int              p_left [N_CH];
    int              d_left [N_CH];
    int              lost_m [N_CH];
    logic [N_CH-1:0] prev_m;

    pulse_shaper_multi #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .LOST_W (LOST_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .channel    (channel),
        .mode       (mode),
        .cfg_width  (cfg_width),
        .cfg_dead   (cfg_dead),
        .lost_clr   (lost_clr),
        .pulse      (pulse),
        .busy       (busy),
        .lost_count (lost_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ch;
        logic        md;
        logic [7:0]  w;
        logic [7:0]  d;
        logic        clr;
        logic [3:0]  ep;
        logic [3:0]  eb;
        logic [15:0] el;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] ch, logic md, logic [7:0] w, logic [7:0] d,
                                logic clr, logic [3:0] ep, logic [3:0] eb, logic [15:0] el);
        vec_t v;
        v.ch = ch; v.md = md; v.w = w; v.d = d; v.clr = clr;
        v.ep = ep; v.eb = eb; v.el = el;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic e;
        int   w;
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                p_left[i] = 0; d_left[i] = 0; lost_m[i] = 0;
            end
            prev_m = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                e = channel[i] & ~prev_m[i];
                if (lost_clr) lost_m[i] = 0;
                else if (e && (p_left[i] + d_left[i] > 0) && lost_m[i] < LMAX) lost_m[i]++;
                if (p_left[i] > 0) p_left[i]--;
                else if (d_left[i] > 0) d_left[i]--;
                else if (mode ? e : channel[i]) begin
                    w = (cfg_width == 0) ? 1 : int'(cfg_width);
                    p_left[i] = w;
                    d_left[i] = int'(cfg_dead);
                end
            end
            prev_m = channel;
        end
    endtask

    // Advance one clock with the inputs currently driven; sample 1 time unit after the edge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        channel  = '0;
        lost_clr = 1'b0;
        step();
        step();
        chk("reset_pulse", 32'(pulse), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_lost", 32'(lost_count), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string nm);
        logic [N_CH-1:0]        ep, eb;
        logic [N_CH*LOST_W-1:0] el;
        for (int i = 0; i < N_CH; i++) begin
            ep[i] = (p_left[i] > 0);
            eb[i] = (p_left[i] + d_left[i] > 0);
            el[i*LOST_W +: LOST_W] = LOST_W'(lost_m[i]);
        end
        chk({nm, "_pulse"}, 32'(pulse), 32'(ep));
        chk({nm, "_busy"}, 32'(busy), 32'(eb));
        chk({nm, "_lost"}, 32'(lost_count), 32'(el));
    endtask

    initial begin
        int hi;
        mode = 1'b1; cfg_width = 8'd2; cfg_dead = 8'd5;
        do_reset();

        // Single edge, W=2 D=5
        vecs.push_back(mk(4'b0001, 1, 2, 5, 0, 4'b0001, 4'b0001, 16'h0));
        vecs.push_back(mk(4'b0000, 1, 2, 5, 0, 4'b0001, 4'b0001, 16'h0));
        vecs.push_back(mk(4'b0000, 1, 2, 5, 0, 4'b0000, 4'b0001, 16'h0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(4'b0000, 1, 2, 5, 0, 4'b0000, 4'b0001, 16'h0));
        vecs.push_back(mk(4'b0000, 1, 2, 5, 0, 4'b0000, 4'b0000, 16'h0));
        // Zero width and dead time: back-to-back retrigger
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0001, 16'h0));
        vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 16'h0));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 0, 4'b0001, 4'b0001, 16'h0));
        vecs.push_back(mk(4'b0000, 1, 0, 0, 0, 4'b0000, 4'b0000, 16'h0));
        // Edges during pulse/dead are lost; clear wins over a simultaneous lost edge
        vecs.push_back(mk(4'b0100, 1, 2, 10, 0, 4'b0100, 4'b0100, 16'h0000));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0100, 4'b0100, 16'h0000));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0000));
        vecs.push_back(mk(4'b0100, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0100));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0100));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0100));
        vecs.push_back(mk(4'b0100, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0200));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0200));
        vecs.push_back(mk(4'b0100, 1, 2, 10, 1, 4'b0000, 4'b0100, 16'h0000));
        vecs.push_back(mk(4'b0000, 1, 2, 10, 0, 4'b0000, 4'b0100, 16'h0000));

        foreach (vecs[n]) begin
            channel = vecs[n].ch; mode = vecs[n].md; cfg_width = vecs[n].w;
            cfg_dead = vecs[n].d; lost_clr = vecs[n].clr;
            step();
            chk($sformatf("tbl%0d_pulse", n), 32'(pulse), 32'(vecs[n].ep));
            chk($sformatf("tbl%0d_busy", n), 32'(busy), 32'(vecs[n].eb));
            chk($sformatf("tbl%0d_lost", n), 32'(lost_count), 32'(vecs[n].el));
        end
        lost_clr = 1'b0;

        // Level mode, held-high input retriggers every W+D+1 = 8 cycles
        mode = 1'b0; cfg_width = 8'd3; cfg_dead = 8'd4;
        do_reset();
        channel = 4'b0010;
        for (int c = 1; c <= 30; c++) begin
            step();
            chk($sformatf("level_c%0d", c), 32'(pulse[1]), 32'(((c - 1) % 8) < 3));
        end
        channel = '0;
        step();
        chk("level_lost", 32'(lost_count), 32'h0);

        // Lost counter saturation during a long dead time
        mode = 1'b1; cfg_width = 8'd2; cfg_dead = 8'd200;
        do_reset();
        channel = 4'b1000;
        step();
        for (int k = 0; k < 20; k++) begin
            channel = '0; step();
            channel = 4'b1000; step();
        end
        channel = '0;
        step();
        chk("sat_lost", 32'(lost_count), 32'hF000);
        chk("sat_busy", 32'(busy), 32'h8);

        // Mid-pulse config change is ignored; reset mid-dead aborts everything
        mode = 1'b1; cfg_width = 8'd10; cfg_dead = 8'd20;
        do_reset();
        channel = 4'b0001;
        step();
        channel = '0;
        hi = pulse[0] ? 1 : 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 2) cfg_width = 8'd2;
            step();
            if (pulse[0]) hi++;
        end
        chk("cfg_hold_width", 32'(hi), 32'd10);
        channel = 4'b0001; step();
        channel = '0; step();
        chk("dead_lost", 32'(lost_count), 32'h1);
        chk("dead_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step();
        chk("abort_pulse", 32'(pulse), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_lost", 32'(lost_count), 32'h0);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) begin
                cfg_width = 8'($urandom_range(7));
                cfg_dead  = 8'($urandom_range(7));
            end
            if ($urandom_range(63) == 0) mode = ~mode;
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(2) == 0) channel[i] = ~channel[i];
            lost_clr = ($urandom_range(49) == 0);
            rst_n    = ($urandom_range(499) != 0);
            step();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
